otter_icache: RTL and testbench

- Direct-mapped, read-only L1 instruction cache between the multicycle OTTER fetch stage and the instruction port (port 1) of the dual-port main memory.
- Hits return the instruction combinationally in the request cycle.
- Misses stall fetch and fill the whole line with back-to-back single-word reads on memory port 1, which has 1-cycle registered read latency.
- Provides a full-cache invalidate for self-modifying code and program reload.

---
 rtl/otter_icache_if.sv | 20 ++
 rtl/otter_icache.sv | 104 ++++++++++
 tb/tb_otter_icache.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/otter_icache_if.sv
// otter_icache_if: fetch-side and memory-port-1 signals of the instruction cache
interface otter_icache_if;
    logic [31:0] PC;
    logic        IF_REQ;
    logic        FLUSH;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        STALL;
    logic [31:0] MEM_ADDR1;
    logic        MEM_READ1;
    logic [31:0] MEM_DOUT1;
    modport master (
        output PC, IF_REQ, FLUSH, MEM_DOUT1,
        input  INSTR, INSTR_VALID, STALL, MEM_ADDR1, MEM_READ1
    );
    modport slave (
        input  PC, IF_REQ, FLUSH, MEM_DOUT1,
        output INSTR, INSTR_VALID, STALL, MEM_ADDR1, MEM_READ1
    );
endinterface

// File: rtl/otter_icache.sv
// otter_icache: direct-mapped read-only instruction cache with line fill and full invalidate
module otter_icache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input logic           CLK,
    input logic           RST_N,
    otter_icache_if.slave bus
);
    localparam int OFS = $clog2(WORDS_PER_LINE);
    localparam int IDX = $clog2(LINES);
    localparam int TAG = 30 - OFS - IDX;
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TAG-1:0]    tags [LINES];
    logic [31:0]       data [LINES][WORDS_PER_LINE];
    logic [29-OFS:0]   miss_line;
    logic [OFS-1:0]    cnt;
    logic [OFS-1:0]    cap_ofs;
    logic              cap_en;
    logic              flush_pending;
    logic              mem_read;
    logic [31:0]       mem_addr;
    logic [OFS-1:0]    ofs;
    logic [IDX-1:0]    idx;
    logic [TAG-1:0]    tag;
    logic [IDX-1:0]    miss_idx;
    logic [TAG-1:0]    miss_tag;
    logic              flushing;
    logic              hit;
    logic              miss;
    logic              unused_pc;
    assign unused_pc = ^bus.PC[1:0];
    assign ofs       = bus.PC[OFS+1:2];
    assign idx       = bus.PC[OFS+IDX+1:OFS+2];
    assign tag       = bus.PC[31:OFS+IDX+2];
    assign miss_idx  = miss_line[IDX-1:0];
    assign miss_tag  = miss_line[29-OFS:IDX];
    assign flushing  = state == IDLE && (bus.FLUSH || flush_pending);
    assign hit       = bus.IF_REQ && state == IDLE && !flushing && valid[idx] && tags[idx] == tag;
    assign miss      = bus.IF_REQ && state == IDLE && !flushing && !hit;
    assign bus.INSTR_VALID = RST_N && hit;
    assign bus.INSTR       = (RST_N && hit) ? data[idx][ofs] : '0;
    assign bus.STALL       = RST_N && (state != IDLE || flushing || miss);
    assign bus.MEM_READ1   = RST_N && mem_read;
    assign bus.MEM_ADDR1   = RST_N ? mem_addr : '0;
    // FSM: start a fill on a miss, stream word reads, then validate the line or apply a deferred flush
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= IDLE;
            valid         <= '0;
            cnt           <= '0;
            cap_en        <= 1'b0;
            flush_pending <= 1'b0;
            mem_read      <= 1'b0;
            mem_addr      <= '0;
        end else begin
            cap_en  <= state == FILL;
            cap_ofs <= cnt;
            case (state)
                IDLE: begin
                    if (flushing) begin
                        valid         <= '0;
                        flush_pending <= 1'b0;
                    end else if (miss) begin
                        miss_line  <= bus.PC[31:OFS+2];
                        valid[idx] <= 1'b0;
                        cnt        <= '0;
                        mem_read   <= 1'b1;
                        mem_addr   <= {bus.PC[31:OFS+2], {(OFS+2){1'b0}}};
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (bus.FLUSH) flush_pending <= 1'b1;
                    if (cnt == OFS'(WORDS_PER_LINE-1)) begin
                        mem_read <= 1'b0;
                        state    <= DONE;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        mem_addr <= mem_addr + 32'd4;
                    end
                end
                DONE: begin
                    if (bus.FLUSH || flush_pending) begin
                        valid         <= '0;
                        flush_pending <= 1'b0;
                    end else begin
                        valid[miss_idx] <= 1'b1;
                    end
                    mem_addr <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Line storage: each returned word lands one cycle after its read; the tag is written as the fill finishes
    always_ff @(posedge CLK) begin
        if (RST_N && cap_en) data[miss_idx][cap_ofs] <= bus.MEM_DOUT1;
        if (RST_N && state == DONE) tags[miss_idx] <= miss_tag;
    end
endmodule

// File: tb/tb_otter_icache.sv
// tb_otter_icache: directed fetch sequences checked against a cycle-level cache model
module tb_otter_icache;
    localparam int L = 16;
    localparam int W = 4;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   go = 1'b0;
    bit   done = 1'b0;
    int   phase = 0;
    int   line = 0;
    bit   pend = 1'b0;
    logic [31:0] base = '0;
    bit   mv [L];
    logic [31:0] mt [L];
    otter_icache_if m();
    otter_icache #(.LINES(L), .WORDS_PER_LINE(W)) dut (.CLK(CLK), .RST_N(RST_N), .bus(m));
    always #5 CLK = ~CLK;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h60;
    endfunction
    // Memory port 1: registered read, garbage when no read was issued
    always @(posedge CLK) m.MEM_DOUT1 <= m.MEM_READ1 ? mem_word(m.MEM_ADDR1) : 32'hDEADBEEF;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: line valid/tag table, fill phase 1..W reading, W+1 finishing; data equals memory
    initial begin
        forever begin
            @(negedge CLK);
            if (done) break;
            if (go) begin
                logic [31:0] pc;
                int i;
                bit fl, h, rq;
                pc = m.PC;
                rq = m.IF_REQ;
                i = int'((pc / (4 * W)) % L);
                fl = phase == 0 && (m.FLUSH || pend);
                h = RST_N && phase == 0 && rq && !fl && mv[i] && mt[i] == pc / (4 * W * L);
                chk("m_valid", m.INSTR_VALID, h);
                chk("m_instr", m.INSTR, h ? mem_word({pc[31:2], 2'b00}) : 32'h0);
                chk("m_stall", m.STALL, RST_N && (phase != 0 || fl || (rq && !h)));
                chk("m_read", m.MEM_READ1, RST_N && phase >= 1 && phase <= W);
                chk("m_addr", m.MEM_ADDR1, (!RST_N || phase == 0) ? 32'h0 :
                    phase <= W ? base + 32'(4 * (phase - 1)) : base + 32'(4 * (W - 1)));
                if (!RST_N) begin
                    foreach (mv[k]) mv[k] = 1'b0;
                    phase = 0;
                    pend = 1'b0;
                end else if (phase == 0) begin
                    if (fl) begin
                        foreach (mv[k]) mv[k] = 1'b0;
                        pend = 1'b0;
                    end else if (rq && !h) begin
                        base = pc & ~32'(4 * W - 1);
                        line = i;
                        mv[i] = 1'b0;
                        phase = 1;
                    end
                end else if (phase <= W) begin
                    if (m.FLUSH) pend = 1'b1;
                    phase++;
                end else begin
                    mv[line] = 1'b1;
                    mt[line] = base / (4 * W * L);
                    if (m.FLUSH || pend) begin
                        foreach (mv[k]) mv[k] = 1'b0;
                        pend = 1'b0;
                    end
                    phase = 0;
                end
            end
        end
    end
    task automatic drive(input logic [31:0] pc, input logic req, input logic fl, input logic rn);
        @(posedge CLK);
        #1;
        m.PC = pc;
        m.IF_REQ = req;
        m.FLUSH = fl;
        RST_N = rn;
        @(negedge CLK);
        #1;
    endtask
    task automatic fetch(input logic [31:0] pc, output int ns, output logic [31:0] ins);
        ns = 0;
        ins = '0;
        for (int k = 0; k < 20; k++) begin
            drive(pc, 1'b1, 1'b0, 1'b1);
            if (m.INSTR_VALID) begin
                ins = m.INSTR;
                return;
            end
            if (m.STALL) ns++;
        end
        total++;
        bad++;
        $display("FAIL fetch_bound: pc %h got no hit within 20 cycles", pc);
    endtask
    initial begin
        int ns, nr;
        logic [31:0] ins;
        logic [31:0] addrs [4];
        logic [31:0] pcs [3];
        m.PC = '0;
        m.IF_REQ = 1'b0;
        m.FLUSH = 1'b0;
        go = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        drive(32'h0, 1'b1, 1'b0, 1'b0);
        chk("rst_stall", m.STALL, 0);
        chk("rst_read", m.MEM_READ1, 0);
        chk("rst_valid", m.INSTR_VALID, 0);
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        chk("idle_addr", m.MEM_ADDR1, 0);
        ns = 0;
        nr = 0;
        for (int k = 0; k < 20; k++) begin
            drive(32'h100, 1'b1, 1'b0, 1'b1);
            if (m.INSTR_VALID) break;
            if (m.STALL) ns++;
            if (m.MEM_READ1) begin
                if (nr < 4) addrs[nr] = m.MEM_ADDR1;
                nr++;
            end
        end
        chk("miss_stall_cycles", ns, 6);
        chk("miss_read_cycles", nr, 4);
        for (int k = 0; k < 4; k++) chk("miss_addr", addrs[k], 32'h100 + 32'(4 * k));
        chk("first_valid", m.INSTR_VALID, 1);
        chk("first_instr", m.INSTR, 32'hA0);
        pcs[0] = 32'h104;
        pcs[1] = 32'h108;
        pcs[2] = 32'h10C;
        for (int k = 0; k < 3; k++) begin
            drive(pcs[k], 1'b1, 1'b0, 1'b1);
            chk("seq_valid", m.INSTR_VALID, 1);
            chk("seq_instr", m.INSTR, 32'hA1 + 32'(k));
            chk("seq_read", m.MEM_READ1, 0);
        end
        fetch(32'h000, ns, ins);
        chk("conf0_stall", ns, 6);
        chk("conf0_instr", ins, 32'h60);
        fetch(32'h100, ns, ins);
        chk("conf1_stall", ns, 6);
        chk("conf1_instr", ins, 32'hA0);
        fetch(32'h000, ns, ins);
        chk("conf2_stall", ns, 6);
        drive(32'h1F0, 1'b1, 1'b0, 1'b1);
        chk("fl_miss_stall", m.STALL, 1);
        drive(32'h1F0, 1'b1, 1'b0, 1'b1);
        drive(32'h1F0, 1'b1, 1'b1, 1'b1);
        chk("fl_fill_read", m.MEM_READ1, 1);
        drive(32'h1F0, 1'b1, 1'b0, 1'b1);
        drive(32'h1F0, 1'b1, 1'b0, 1'b1);
        drive(32'h1F0, 1'b1, 1'b0, 1'b1);
        chk("fl_done_read", m.MEM_READ1, 0);
        chk("fl_done_addr", m.MEM_ADDR1, 32'h1FC);
        fetch(32'h1F0, ns, ins);
        chk("fl_refetch_stall", ns, 6);
        chk("fl_refetch_instr", ins, 32'hDC);
        drive(32'h300, 1'b1, 1'b0, 1'b1);
        drive(32'h300, 1'b1, 1'b0, 1'b1);
        drive(32'h300, 1'b1, 1'b0, 1'b1);
        drive(32'h300, 1'b1, 1'b0, 1'b0);
        chk("rstfill_read", m.MEM_READ1, 0);
        chk("rstfill_stall", m.STALL, 0);
        fetch(32'h300, ns, ins);
        chk("rstfill_refetch_stall", ns, 6);
        chk("rstfill_instr", ins, 32'h120);
        drive(32'h400, 1'b1, 1'b1, 1'b1);
        chk("flmiss_stall", m.STALL, 1);
        chk("flmiss_read", m.MEM_READ1, 0);
        chk("flmiss_valid", m.INSTR_VALID, 0);
        drive(32'h400, 1'b1, 1'b0, 1'b1);
        chk("flmiss_next_stall", m.STALL, 1);
        chk("flmiss_next_read", m.MEM_READ1, 0);
        drive(32'h400, 1'b1, 1'b0, 1'b1);
        chk("flmiss_fill_read", m.MEM_READ1, 1);
        chk("flmiss_fill_addr", m.MEM_ADDR1, 32'h400);
        fetch(32'h400, ns, ins);
        chk("flmiss_rest_stall", ns, 4);
        chk("flmiss_instr", ins, 32'h160);
        drive(32'h400, 1'b0, 1'b0, 1'b1);
        chk("idle_no_req_valid", m.INSTR_VALID, 0);
        done = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
